sad_operand_sram: RTL and testbench
===================================

Name: sad_operand_sram

Overview:
- Single-port synchronous byte memory that answers the SAD datapath's operand fetches (Addr/Di/Do/RW/En). Two instances back the SAD engine, one for the A block and one for the B block.
- Adds two sequential features:
  - a post-reset clear sequencer;
  - a streaming load port with a valid/ready handshake, so a host can fill the operand blocks at runtime instead of relying only on $readmemh.
- Array name is Memory, so benches can still preload it with $readmemh.

Parameters:
A_WIDTH, 15, address width; depth is 2**A_WIDTH bytes
D_WIDTH, 8, data width
CLEAR_ON_RST, 1, 1 = zero the whole array after reset; 0 = skip clear and go straight to SERVE (preserves $readmemh contents)

Ports:
Clk  in  1  clock; all activity on the rising edge
Rst  in  1  synchronous, active-high reset
Di  in  D_WIDTH  write data from the SAD side
Do  out  D_WIDTH  registered read data to the SAD side
Addr  in  A_WIDTH  SAD-side address
RW  in  1  1 = write, 0 = read (qualified by En)
En  in  1  SAD-side access enable
Ready  out  1  1 = SERVE state, SAD-side accesses honoured
Load_Start  in  1  pulse: begin a load burst at Load_Base (honoured in SERVE only)
Load_Base  in  A_WIDTH  first load address, sampled with Load_Start
Load_Valid  in  1  Load_Data valid
Load_Data  in  D_WIDTH  byte to store
Load_Last  in  1  marks the final byte of the burst
Load_Ready  out  1  1 = LOAD state, byte accepted when Load_Valid=1

Behaviour:
- Reset (Rst=1 at an edge, from any state, including mid-CLEAR or mid-LOAD):
  - Do=0, Ready=0, Load_Ready=0, internal address counter=0.
  - Next state is CLEAR if CLEAR_ON_RST=1, otherwise SERVE.
  - Reset does not touch the array directly.
- States:
  - CLEAR: one write of 0 per cycle to Memory[cnt]; cnt increments by 1. On the cycle cnt = 2**A_WIDTH-1 is written, go to SERVE. Clear takes exactly 2**A_WIDTH cycles.
  - SERVE: Ready=1.
    - En=1, RW=0: Do <= Memory[Addr] at that edge. Read latency is 1 cycle; Do holds until the next read.
    - En=1, RW=1: Memory[Addr] <= Di; Do is unchanged.
    - En=0: no access; Do holds.
    - Load_Start=1: go to LOAD, cnt <= Load_Base. Any SAD access presented on that same edge is still performed.
  - LOAD: Ready=0; SAD-side En is ignored (no write, Do holds). Load_Ready=1.
    - Each edge with Load_Valid=1 writes Memory[cnt] <= Load_Data and increments cnt.
    - Load_Valid=0 stalls with no write.
    - Accepting a byte with Load_Last=1 returns to SERVE.
    - Accepting a byte at cnt = 2**A_WIDTH-1 also returns to SERVE (no wrap), even if Load_Last=0; later bytes are not accepted.
- Load_Start is ignored in CLEAR and LOAD.
- Ready and Load_Ready are registered and update on the same edge as the state change.
- Read-before-write ordering does not arise (single port).
- All address arithmetic is unsigned, A_WIDTH bits.
- Out-of-range addresses cannot occur: the address space is exactly the depth.

Test Plan:
1. A_WIDTH=4, CLEAR_ON_RST=1: pulse Rst for 1 cycle -> Ready=0 for exactly 16 cycles, then 1; every read of addresses 0..15 returns 0x00.
2. CLEAR_ON_RST=0, $readmemh preload with Memory[5]=0x3C: after reset, En=1, RW=0, Addr=5 at edge N -> Do=0x3C after edge N; En=0 for 3 cycles -> Do stays 0x3C.
3. Write Di=0xA5 to Addr=7, then read Addr=7 -> Do=0xA5 one cycle after the read edge; Do unchanged during the write cycle.
4. Load_Start with Load_Base=2; bytes 0x11, 0x22, 0x33 (Last on 0x33), with Load_Valid=0 for one cycle between 0x22 and 0x33 -> Memory[2..4]=11,22,33, Memory[5] untouched. Ready=0 throughout; a SAD write attempted during LOAD has no effect.
5. A_WIDTH=4: load from Load_Base=14 with 3 valid bytes and no Last -> Memory[14], Memory[15] written; return to SERVE after the 2nd byte; Memory[0] unchanged.
6. Assert Rst during LOAD (after 1 byte) and during CLEAR -> outputs are 0 on the next edge; CLEAR restarts from address 0 and again takes the full 16 cycles.

Source files
------------

// File: rtl/sad_operand_sram.sv
// Single-port byte SRAM serving SAD operand fetches, with a post-reset clear
// sequencer and a valid/ready streaming load port for runtime fills.
module sad_operand_sram #(
  parameter int A_WIDTH      = 15,
  parameter int D_WIDTH      = 8,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [D_WIDTH-1:0] Di,
  output logic [D_WIDTH-1:0] Do,
  input  logic [A_WIDTH-1:0] Addr,
  input  logic               RW,
  input  logic               En,
  output logic               Ready,
  input  logic               Load_Start,
  input  logic [A_WIDTH-1:0] Load_Base,
  input  logic               Load_Valid,
  input  logic [D_WIDTH-1:0] Load_Data,
  input  logic               Load_Last,
  output logic               Load_Ready
);

  localparam int DEPTH = 2**A_WIDTH;
  localparam logic [A_WIDTH-1:0] CNT_MAX = {A_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_CLEAR, S_SERVE, S_LOAD} state_e;

  state_e             state_q;
  logic [A_WIDTH-1:0] cnt_q;
  logic [D_WIDTH-1:0] do_q;
  logic               ready_q;
  logic               load_ready_q;

  logic [D_WIDTH-1:0] Memory [DEPTH];

  logic               mem_we_d;
  logic [A_WIDTH-1:0] mem_wa_d;
  logic [D_WIDTH-1:0] mem_wd_d;

  // One write port shared by clear, SAD writes and the load stream; reset
  // edges never write so the array is left to the clear sequencer.
  always_comb begin
    mem_we_d = 1'b0;
    mem_wa_d = Addr;
    mem_wd_d = Di;
    if (!Rst) begin
      unique case (state_q)
        S_CLEAR: begin
          mem_we_d = 1'b1;
          mem_wa_d = cnt_q;
          mem_wd_d = '0;
        end
        S_SERVE: mem_we_d = En && RW;
        S_LOAD: begin
          mem_we_d = Load_Valid;
          mem_wa_d = cnt_q;
          mem_wd_d = Load_Data;
        end
        default: mem_we_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we_d) Memory[mem_wa_d] <= mem_wd_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= CLEAR_ON_RST ? S_CLEAR : S_SERVE;
      cnt_q        <= '0;
      do_q         <= '0;
      ready_q      <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_MAX) begin
            state_q <= S_SERVE;
            ready_q <= 1'b1;
          end
        end
        S_SERVE: begin
          ready_q      <= 1'b1;
          load_ready_q <= 1'b0;
          if (En && !RW) do_q <= Memory[Addr];
          // The SAD access on the Load_Start edge is still performed above.
          if (Load_Start) begin
            state_q      <= S_LOAD;
            cnt_q        <= Load_Base;
            ready_q      <= 1'b0;
            load_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (Load_Valid) begin
            cnt_q <= cnt_q + 1'b1;
            // Top of the array ends the burst rather than wrapping to 0.
            if (Load_Last || cnt_q == CNT_MAX) begin
              state_q      <= S_SERVE;
              ready_q      <= 1'b1;
              load_ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q      <= S_SERVE;
          ready_q      <= 1'b0;
          load_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign Do         = do_q;
  assign Ready      = ready_q;
  assign Load_Ready = load_ready_q;

endmodule

// File: tb/tb_sad_operand_sram.sv
// Directed bench for sad_operand_sram (A_WIDTH=4): clear sequencing, SAD
// reads/writes from a vector table, load bursts, and reset mid-operation.
module tb_sad_operand_sram;

  logic       Clk = 1'b0;
  logic       Rst, Rst_n;
  logic [7:0] Di, Do, Load_Data;
  logic [3:0] Addr, Load_Base;
  logic       RW, En, Ready, Load_Start, Load_Valid, Load_Last, Load_Ready;

  logic [7:0] n_Di, n_Do;
  logic [3:0] n_Addr;
  logic       n_RW, n_En, n_Ready, n_Load_Ready;

  int nchk = 0;
  int nfail = 0;

  always #5 Clk = ~Clk;

  sad_operand_sram #(.A_WIDTH(4), .D_WIDTH(8), .CLEAR_ON_RST(1'b1)) u_clr (
    .Clk(Clk), .Rst(Rst), .Di(Di), .Do(Do), .Addr(Addr), .RW(RW), .En(En),
    .Ready(Ready), .Load_Start(Load_Start), .Load_Base(Load_Base),
    .Load_Valid(Load_Valid), .Load_Data(Load_Data), .Load_Last(Load_Last),
    .Load_Ready(Load_Ready));

  sad_operand_sram #(.A_WIDTH(4), .D_WIDTH(8), .CLEAR_ON_RST(1'b0)) u_nc (
    .Clk(Clk), .Rst(Rst_n), .Di(n_Di), .Do(n_Do), .Addr(n_Addr), .RW(n_RW),
    .En(n_En), .Ready(n_Ready), .Load_Start(1'b0), .Load_Base(4'd0),
    .Load_Valid(1'b0), .Load_Data(8'd0), .Load_Last(1'b0),
    .Load_Ready(n_Load_Ready));

  typedef struct {
    logic       en;
    logic       rw;
    logic [3:0] addr;
    logic [7:0] di;
    logic [7:0] exp_do;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic sad(input logic en, input logic rw, input logic [3:0] a, input logic [7:0] d);
    En = en; RW = rw; Addr = a; Di = d;
    step();
    En = 1'b0; RW = 1'b0;
  endtask

  // Counts cycles with Ready=0 starting from the reset sample (already low).
  task automatic wait_clear(input string name);
    int n = 1;
    while (!Ready && n < 40) begin
      step();
      if (!Ready) n++;
    end
    chk(name, n, 16);
  endtask

  initial begin
    Rst = 1'b1; Rst_n = 1'b1;
    Di = '0; Addr = '0; RW = 1'b0; En = 1'b0;
    Load_Start = 1'b0; Load_Base = '0; Load_Valid = 1'b0; Load_Data = '0; Load_Last = 1'b0;
    n_Di = '0; n_Addr = '0; n_RW = 1'b0; n_En = 1'b0;

    vt[0]  = '{1'b1, 1'b1, 4'd7,  8'hA5, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 4'd7,  8'h00, 8'hA5};
    vt[2]  = '{1'b1, 1'b1, 4'd3,  8'h5A, 8'hA5};
    vt[3]  = '{1'b0, 1'b0, 4'd3,  8'h00, 8'hA5};
    vt[4]  = '{1'b1, 1'b0, 4'd3,  8'h00, 8'h5A};
    vt[5]  = '{1'b1, 1'b0, 4'd7,  8'h00, 8'hA5};
    vt[6]  = '{1'b1, 1'b1, 4'd0,  8'hFF, 8'hA5};
    vt[7]  = '{1'b1, 1'b0, 4'd0,  8'h00, 8'hFF};
    vt[8]  = '{1'b0, 1'b1, 4'd0,  8'h12, 8'hFF};
    vt[9]  = '{1'b1, 1'b0, 4'd0,  8'h00, 8'hFF};
    vt[10] = '{1'b1, 1'b1, 4'd15, 8'hC3, 8'hFF};
    vt[11] = '{1'b1, 1'b0, 4'd15, 8'h00, 8'hC3};

    // Reset and full clear
    step();
    chk("rst_do", Do, 0);
    chk("rst_ready", Ready, 0);
    chk("rst_load_ready", Load_Ready, 0);
    Rst = 1'b0;
    wait_clear("clear_cycles");
    for (int i = 0; i < 16; i++) begin
      sad(1'b1, 1'b0, i[3:0], 8'h00);
      chk($sformatf("clear_rd%0d", i), Do, 0);
    end

    // No-clear instance: SERVE straight after reset
    step();
    chk("nc_rst_ready", n_Ready, 0);
    chk("nc_rst_do", n_Do, 0);
    Rst_n = 1'b0;
    step();
    chk("nc_ready", n_Ready, 1);
    n_En = 1'b1; n_RW = 1'b1; n_Addr = 4'd5; n_Di = 8'h3C;
    step();
    chk("nc_wr_do_hold", n_Do, 0);
    n_RW = 1'b0;
    step();
    chk("nc_rd5", n_Do, 8'h3C);
    n_En = 1'b0; n_Addr = 4'd6;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("nc_hold%0d", i), n_Do, 8'h3C);
    end

    // SAD-side vector table
    foreach (vt[i]) begin
      sad(vt[i].en, vt[i].rw, vt[i].addr, vt[i].di);
      chk($sformatf("vec%0d_do", i), Do, vt[i].exp_do);
      chk($sformatf("vec%0d_ready", i), Ready, 1);
    end

    // Load burst at base 2 with a stall and an ignored SAD write
    Load_Start = 1'b1; Load_Base = 4'd2;
    sad(1'b1, 1'b0, 4'd0, 8'h00);
    Load_Start = 1'b0;
    chk("ld_start_rd", Do, 8'hFF);
    chk("ld_start_ready", Ready, 0);
    chk("ld_start_lr", Load_Ready, 1);
    Load_Valid = 1'b1; Load_Data = 8'h11; step();
    Load_Data = 8'h22; step();
    chk("ld_mid_ready", Ready, 0);
    Load_Valid = 1'b0; Load_Start = 1'b1; Load_Base = 4'd9;
    sad(1'b1, 1'b1, 4'd5, 8'hEE);
    Load_Start = 1'b0;
    chk("ld_stall_do", Do, 8'hFF);
    chk("ld_stall_ready", Ready, 0);
    chk("ld_stall_lr", Load_Ready, 1);
    Load_Valid = 1'b1; Load_Data = 8'h33; Load_Last = 1'b1; step();
    chk("ld_end_ready", Ready, 1);
    chk("ld_end_lr", Load_Ready, 0);
    Load_Data = 8'h77; Load_Last = 1'b0; step();
    Load_Valid = 1'b0;
    sad(1'b1, 1'b0, 4'd2, 8'h00); chk("ld_rd2", Do, 8'h11);
    sad(1'b1, 1'b0, 4'd3, 8'h00); chk("ld_rd3", Do, 8'h22);
    sad(1'b1, 1'b0, 4'd4, 8'h00); chk("ld_rd4", Do, 8'h33);
    sad(1'b1, 1'b0, 4'd5, 8'h00); chk("ld_rd5", Do, 8'h00);
    sad(1'b1, 1'b0, 4'd9, 8'h00); chk("ld_rd9", Do, 8'h00);

    // Load hitting the top of the array without Last
    Load_Start = 1'b1; Load_Base = 4'd14; step();
    Load_Start = 1'b0;
    Load_Valid = 1'b1; Load_Data = 8'hAA; step();
    chk("top_b1_lr", Load_Ready, 1);
    Load_Data = 8'hBB; step();
    chk("top_b2_ready", Ready, 1);
    chk("top_b2_lr", Load_Ready, 0);
    Load_Data = 8'hCC; step();
    Load_Valid = 1'b0;
    sad(1'b1, 1'b0, 4'd14, 8'h00); chk("top_rd14", Do, 8'hAA);
    sad(1'b1, 1'b0, 4'd15, 8'h00); chk("top_rd15", Do, 8'hBB);
    sad(1'b1, 1'b0, 4'd0, 8'h00);  chk("top_rd0", Do, 8'hFF);

    // Reset mid-LOAD, then mid-CLEAR
    Load_Start = 1'b1; Load_Base = 4'd8; step();
    Load_Start = 1'b0;
    Load_Valid = 1'b1; Load_Data = 8'h99; step();
    Rst = 1'b1; Load_Data = 8'h55; step();
    Load_Valid = 1'b0;
    chk("rstld_do", Do, 0);
    chk("rstld_ready", Ready, 0);
    chk("rstld_lr", Load_Ready, 0);
    Rst = 1'b0;
    repeat (5) step();
    chk("rstclr_pre_ready", Ready, 0);
    Rst = 1'b1; step();
    chk("rstclr_do", Do, 0);
    chk("rstclr_ready", Ready, 0);
    Rst = 1'b0;
    wait_clear("reclear_cycles");
    sad(1'b1, 1'b0, 4'd0, 8'h00);  chk("reclr_rd0", Do, 0);
    sad(1'b1, 1'b0, 4'd3, 8'h00);  chk("reclr_rd3", Do, 0);
    sad(1'b1, 1'b0, 4'd8, 8'h00);  chk("reclr_rd8", Do, 0);
    sad(1'b1, 1'b0, 4'd15, 8'h00); chk("reclr_rd15", Do, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
